cond_flag_unit: RTL and testbench

COND_FLAG_UNIT -- requirements
Module: cond_flag_unit

---
 rtl/cond_flag_unit_pkg.sv | 29 ++
 rtl/cond_flag_unit_eval.sv | 37 +++
 rtl/cond_flag_unit.sv | 73 +++++++
 tb/tb_cond_flag_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cond_flag_unit_pkg.sv
// Shared condition-flag types: ARMv8 condition codes,
// the {V,C,N,Z} flag struct and its bit positions.
package cond_flag_unit_pkg;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [3:0] {
        EQ = 4'd0,  NE = 4'd1,  HS = 4'd2,  LO = 4'd3,
        MI = 4'd4,  PL = 4'd5,  VS = 4'd6,  VC = 4'd7,
        HI = 4'd8,  LS = 4'd9,  GE = 4'd10, LT = 4'd11,
        GT = 4'd12, LE = 4'd13, AL = 4'd14, NV = 4'd15
    } cond_t;

    typedef struct packed {
        logic v;
        logic c;
        logic n;
        logic z;
    } flags_t;

    typedef struct packed {
        logic   valid;
        flags_t flags;
    } pipe_entry_t;

endpackage

// File: rtl/cond_flag_unit_eval.sv
// Combinational ARMv8 condition evaluator.
// Ports: flags {V,C,N,Z}, cond code in; taken out.
module cond_eval
    import cond_flag_unit_pkg::*;
(
    input  flags_t flags,
    input  cond_t  cond,
    output logic   taken
);

    logic gt;

    assign gt = ~flags.z & (flags.n == flags.v);

    always_comb begin
        taken = 1'b0;
        unique case (cond)
            EQ: taken = flags.z;
            NE: taken = ~flags.z;
            HS: taken = flags.c;
            LO: taken = ~flags.c;
            MI: taken = flags.n;
            PL: taken = ~flags.n;
            VS: taken = flags.v;
            VC: taken = ~flags.v;
            HI: taken = flags.c & ~flags.z;
            LS: taken = ~(flags.c & ~flags.z);
            GE: taken = (flags.n == flags.v);
            LT: taken = (flags.n != flags.v);
            GT: taken = gt;
            LE: taken = ~gt;
            AL: taken = 1'b1;
            NV: taken = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_flag_unit.sv
// Flag commit pipeline with branch flag forwarding/stall.
// Ports: clk, reset; EX producer (ex_valid, ex_set_flags,
// ex_flags, flush); ID branch (br_valid, br_cond);
// outputs br_taken, br_stall, arch_flags, taken_cnt.
module cond_flag_unit
    import cond_flag_unit_pkg::*;
#(
    parameter int COMMIT_LAT = 2,
    parameter int EX_FWD     = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic             ex_set_flags,
    input  logic [3:0]       ex_flags,
    input  logic             flush,
    input  logic             br_valid,
    input  logic [3:0]       br_cond,
    output logic             br_taken,
    output logic             br_stall,
    output logic [3:0]       arch_flags,
    output logic [CNT_W-1:0] taken_cnt
);

    pipe_entry_t pipe [COMMIT_LAT];
    flags_t      arch_q;
    flags_t      src;
    logic        ex_live;
    logic        cond_hit;
    logic        stall_hit;

    assign ex_live = ex_valid & ex_set_flags & ~flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < COMMIT_LAT; i++)
                pipe[i] <= '0;
            arch_q    <= '0;
            taken_cnt <= '0;
        end else begin
            pipe[0] <= '{valid: ex_live, flags: flags_t'(ex_flags)};
            for (int i = 1; i < COMMIT_LAT; i++)
                pipe[i] <= pipe[i-1];
            if (pipe[COMMIT_LAT-1].valid)
                arch_q <= pipe[COMMIT_LAT-1].flags;
            if (br_taken && (taken_cnt != {CNT_W{1'b1}}))
                taken_cnt <= taken_cnt + 1'b1;
        end
    end

    // Slot 0 is youngest; scanning oldest-first lets it win.
    always_comb begin
        src = arch_q;
        for (int i = COMMIT_LAT - 1; i >= 0; i--)
            if (pipe[i].valid)
                src = pipe[i].flags;
        if ((EX_FWD != 0) && ex_live)
            src = flags_t'(ex_flags);
    end

    cond_eval u_eval (
        .flags (src),
        .cond  (cond_t'(br_cond)),
        .taken (cond_hit)
    );

    assign stall_hit  = (EX_FWD == 0) & ex_live & br_valid;
    assign br_stall   = stall_hit;
    assign br_taken   = br_valid & cond_hit & ~stall_hit;
    assign arch_flags = arch_q;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed testbench for cond_flag_unit: three instances
// (default, stall mode, 3-bit counter) share one stimulus.
module tb_cond_flag_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       ex_valid;
    logic       ex_set_flags;
    logic [3:0] ex_flags;
    logic       flush;
    logic       br_valid;
    logic [3:0] br_cond;

    logic        a_taken, a_stall;
    logic [3:0]  a_arch;
    logic [15:0] a_cnt;
    logic        b_taken, b_stall;
    logic [3:0]  b_arch;
    logic [15:0] b_cnt;
    logic        c_taken, c_stall;
    logic [3:0]  c_arch;
    logic [2:0]  c_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cond_flag_unit u_a (
        .clk(clk), .reset(reset), .ex_valid(ex_valid),
        .ex_set_flags(ex_set_flags), .ex_flags(ex_flags),
        .flush(flush), .br_valid(br_valid), .br_cond(br_cond),
        .br_taken(a_taken), .br_stall(a_stall),
        .arch_flags(a_arch), .taken_cnt(a_cnt)
    );

    cond_flag_unit #(.EX_FWD(0)) u_b (
        .clk(clk), .reset(reset), .ex_valid(ex_valid),
        .ex_set_flags(ex_set_flags), .ex_flags(ex_flags),
        .flush(flush), .br_valid(br_valid), .br_cond(br_cond),
        .br_taken(b_taken), .br_stall(b_stall),
        .arch_flags(b_arch), .taken_cnt(b_cnt)
    );

    cond_flag_unit #(.CNT_W(3)) u_c (
        .clk(clk), .reset(reset), .ex_valid(ex_valid),
        .ex_set_flags(ex_set_flags), .ex_flags(ex_flags),
        .flush(flush), .br_valid(br_valid), .br_cond(br_cond),
        .br_taken(c_taken), .br_stall(c_stall),
        .arch_flags(c_arch), .taken_cnt(c_cnt)
    );

    task automatic idle();
        ex_valid = 0; ex_set_flags = 0; ex_flags = 0;
        flush = 0; br_valid = 0; br_cond = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1; idle(); step(); reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; idle();
        ex_valid = 1; ex_set_flags = 1; ex_flags = 4'hF;
        step(); step();
        idle(); reset = 0;
        n_cmp++;
        if (a_arch !== 4'h0) begin n_err++;
            $display("FAIL reset_arch got %h exp 0", a_arch); end
        n_cmp++;
        if (a_cnt !== 16'd0) begin n_err++;
            $display("FAIL reset_cnt got %0d exp 0", a_cnt); end
        n_cmp++;
        if (c_cnt !== 3'd0) begin n_err++;
            $display("FAIL reset_cnt3 got %0d exp 0", c_cnt); end
    endtask

    task automatic test_basic();
        br_valid = 1; br_cond = 4'd0; #1;
        n_cmp++;
        if (a_taken !== 1'b0) begin n_err++;
            $display("FAIL eq_z0 got %b exp 0", a_taken); end
        br_cond = 4'd14; #1;
        n_cmp++;
        if (a_taken !== 1'b1) begin n_err++;
            $display("FAIL al got %b exp 1", a_taken); end
        step(); idle();
        n_cmp++;
        if (a_cnt !== 16'd1) begin n_err++;
            $display("FAIL cnt_one got %0d exp 1", a_cnt); end
    endtask

    task automatic test_fwd();
        ex_valid = 1; ex_set_flags = 1; ex_flags = 4'b0010;
        br_valid = 1; br_cond = 4'd11; #1;
        n_cmp++;
        if (a_taken !== 1'b1 || a_stall !== 1'b0) begin n_err++;
            $display("FAIL fwd_lt got t=%b s=%b exp t=1 s=0",
                     a_taken, a_stall); end
        n_cmp++;
        if (b_taken !== 1'b0 || b_stall !== 1'b1) begin n_err++;
            $display("FAIL stall_lt got t=%b s=%b exp t=0 s=1",
                     b_taken, b_stall); end
        step();
        ex_valid = 0; ex_set_flags = 0; ex_flags = 0; #1;
        n_cmp++;
        if (b_taken !== 1'b1 || b_stall !== 1'b0) begin n_err++;
            $display("FAIL pipe_lt got t=%b s=%b exp t=1 s=0",
                     b_taken, b_stall); end
        step(); idle();
        n_cmp++;
        if (a_arch !== 4'b0000) begin n_err++;
            $display("FAIL early_commit got %b exp 0000", a_arch); end
        step();
        n_cmp++;
        if (a_arch !== 4'b0010) begin n_err++;
            $display("FAIL fwd_commit got %b exp 0010", a_arch); end
        n_cmp++;
        if (b_cnt !== 16'd2) begin n_err++;
            $display("FAIL stall_cnt got %0d exp 2", b_cnt); end
    endtask

    task automatic test_flush();
        do_reset();
        ex_valid = 1; ex_set_flags = 1; ex_flags = 4'b0001;
        flush = 1; br_valid = 1; br_cond = 4'd0; #1;
        n_cmp++;
        if (a_taken !== 1'b0) begin n_err++;
            $display("FAIL flush_eq got %b exp 0", a_taken); end
        n_cmp++;
        if (b_stall !== 1'b0) begin n_err++;
            $display("FAIL flush_stall got %b exp 0", b_stall); end
        step(); idle(); step(); step(); step();
        n_cmp++;
        if (a_arch !== 4'b0000) begin n_err++;
            $display("FAIL flush_arch got %b exp 0000", a_arch); end
    endtask

    task automatic test_back_to_back();
        ex_valid = 1; ex_set_flags = 1; ex_flags = 4'b0001;
        step();
        ex_flags = 4'b0100;
        step();
        idle(); br_valid = 1; br_cond = 4'd2; #1;
        n_cmp++;
        if (a_taken !== 1'b1) begin n_err++;
            $display("FAIL young_hs got %b exp 1", a_taken); end
        br_cond = 4'd0; #1;
        n_cmp++;
        if (a_taken !== 1'b0) begin n_err++;
            $display("FAIL young_eq got %b exp 0", a_taken); end
        step(); idle();
        n_cmp++;
        if (a_arch !== 4'b0001) begin n_err++;
            $display("FAIL b2b_old got %b exp 0001", a_arch); end
        step();
        n_cmp++;
        if (a_arch !== 4'b0100) begin n_err++;
            $display("FAIL b2b_young got %b exp 0100", a_arch); end
        ex_valid = 1; ex_set_flags = 0; ex_flags = 4'hF;
        br_valid = 1; br_cond = 4'd0; #1;
        n_cmp++;
        if (a_taken !== 1'b0 || b_stall !== 1'b0) begin n_err++;
            $display("FAIL no_set got t=%b s=%b exp t=0 s=0",
                     a_taken, b_stall); end
        idle();
    endtask

    task automatic test_saturate();
        do_reset();
        br_valid = 1; br_cond = 4'd14;
        for (int i = 0; i < 8; i++) step();
        n_cmp++;
        if (c_cnt !== 3'd7) begin n_err++;
            $display("FAIL sat_cnt got %0d exp 7", c_cnt); end
        n_cmp++;
        if (a_cnt !== 16'd8) begin n_err++;
            $display("FAIL wide_cnt got %0d exp 8", a_cnt); end
        step(); step();
        n_cmp++;
        if (c_cnt !== 3'd7) begin n_err++;
            $display("FAIL sat_hold got %0d exp 7", c_cnt); end
        idle();
    endtask

    task automatic test_reset_mid();
        ex_valid = 1; ex_set_flags = 1; ex_flags = 4'hF;
        step();
        idle(); reset = 1; step(); reset = 0;
        n_cmp++;
        if (a_arch !== 4'h0 || c_cnt !== 3'd0) begin n_err++;
            $display("FAIL mid_reset got a=%h c=%0d exp 0 0",
                     a_arch, c_cnt); end
        step(); step(); step();
        n_cmp++;
        if (a_arch !== 4'h0) begin n_err++;
            $display("FAIL discard got %h exp 0", a_arch); end
    endtask

    initial begin
        idle(); reset = 1;
        test_reset();
        test_basic();
        test_fwd();
        test_flush();
        test_back_to_back();
        test_saturate();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
